// File: rtl/hdd_sd_bridge.sv
// Bridges Apple II HDD sector requests onto the hps_io sd_rd/sd_wr/sd_ack handshake.
// Latency: request pulse to sd_rd/sd_wr is 2 edges; ack edges act 2 edges after sd_ack moves.
// Backpressure: cpu_wait stalls the CPU while a transfer runs; one request per type is queued.
module hdd_sd_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 14_000_000,
  parameter int unsigned CNT_W          = 24
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        hdd_read,
  input  logic        hdd_write,
  input  logic [31:0] hdd_lba_in,
  input  logic        img_mounted,
  input  logic [63:0] img_size,
  input  logic        img_readonly,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  output logic        hdd_mounted,
  output logic        hdd_protect,
  output logic        cpu_wait,
  output logic        hdd_error
);

  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

  state_t             state;
  logic               rd_pend;
  logic               wr_pend;
  logic [31:0]        rd_lba;
  logic [31:0]        wr_lba;
  logic               ack_s;
  logic               ack_d;
  logic [CNT_W-1:0]   cnt;

  logic               take_rd;
  logic               take_wr;
  logic               reject;
  logic               ack_rise;
  logic               ack_fall;
  logic               timeout;

  // Request selection in IDLE (write wins), rejection, ack edges and timeout compare.
  always_comb begin
    take_wr  = (state == IDLE) && wr_pend;
    take_rd  = (state == IDLE) && rd_pend && !wr_pend;
    reject   = !hdd_mounted || (take_wr && hdd_protect);
    ack_rise = ack_s && !ack_d;
    ack_fall = !ack_s && ack_d;
    timeout  = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  end

  // Ack is registered once, then edge-detected against its own delayed copy.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      ack_s <= 1'b0;
      ack_d <= 1'b0;
    end else begin
      ack_s <= sd_ack;
      ack_d <= ack_s;
    end
  end

  // Mount state follows the slot strobe only; the transfer FSM never looks at it mid-flight.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      hdd_mounted <= 1'b0;
      hdd_protect <= 1'b0;
    end else if (img_mounted) begin
      hdd_mounted <= (img_size != 64'd0);
      hdd_protect <= img_readonly;
    end
  end

  // One pending slot per request type; a new pulse wins over a same-cycle clear.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      rd_pend <= 1'b0;
      wr_pend <= 1'b0;
      rd_lba  <= '0;
      wr_lba  <= '0;
    end else begin
      if (hdd_read) begin
        rd_pend <= 1'b1;
        rd_lba  <= hdd_lba_in;
      end else if (take_rd) begin
        rd_pend <= 1'b0;
      end
      if (hdd_write) begin
        wr_pend <= 1'b1;
        wr_lba  <= hdd_lba_in;
      end else if (take_wr) begin
        wr_pend <= 1'b0;
      end
    end
  end

  // Transfer FSM with registered handshake outputs; ack edges beat the timeout.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sd_lba    <= '0;
      sd_rd     <= 1'b0;
      sd_wr     <= 1'b0;
      cpu_wait  <= 1'b0;
      hdd_error <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take_wr || take_rd) begin
            if (reject) begin
              hdd_error <= 1'b1;
            end else begin
              sd_lba    <= take_wr ? wr_lba : rd_lba;
              sd_wr     <= take_wr;
              sd_rd     <= take_rd;
              cpu_wait  <= 1'b1;
              hdd_error <= 1'b0;
              cnt       <= '0;
              state     <= REQ;
            end
          end
        end
        REQ: begin
          cnt <= cnt + 1'b1;
          if (ack_rise) begin
            sd_rd <= 1'b0;
            sd_wr <= 1'b0;
            state <= XFER;
          end else if (timeout) begin
            sd_rd     <= 1'b0;
            sd_wr     <= 1'b0;
            cpu_wait  <= 1'b0;
            hdd_error <= 1'b1;
            state     <= IDLE;
          end
        end
        XFER: begin
          cnt <= cnt + 1'b1;
          if (ack_fall) begin
            cpu_wait <= 1'b0;
            state    <= IDLE;
          end else if (timeout) begin
            sd_rd     <= 1'b0;
            sd_wr     <= 1'b0;
            cpu_wait  <= 1'b0;
            hdd_error <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hdd_sd_bridge.sv
// Scoreboard bench for hdd_sd_bridge: stimulus pushes expected output snapshots with
// the edge count at which they must appear; a monitor compares on every output change.
module tb_hdd_sd_bridge;

  localparam int TO = 100;

  logic        clk_sys;
  logic        reset;
  logic        hdd_read;
  logic        hdd_write;
  logic [31:0] hdd_lba_in;
  logic        img_mounted;
  logic [63:0] img_size;
  logic        img_readonly;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic        hdd_mounted;
  logic        hdd_protect;
  logic        cpu_wait;
  logic        hdd_error;

  hdd_sd_bridge #(.TIMEOUT_CYCLES(TO), .CNT_W(24)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .hdd_read    (hdd_read),
    .hdd_write   (hdd_write),
    .hdd_lba_in  (hdd_lba_in),
    .img_mounted (img_mounted),
    .img_size    (img_size),
    .img_readonly(img_readonly),
    .sd_lba      (sd_lba),
    .sd_rd       (sd_rd),
    .sd_wr       (sd_wr),
    .sd_ack      (sd_ack),
    .hdd_mounted (hdd_mounted),
    .hdd_protect (hdd_protect),
    .cpu_wait    (cpu_wait),
    .hdd_error   (hdd_error)
  );

  typedef struct packed {
    logic        mounted;
    logic        protect;
    logic        rd;
    logic        wr;
    logic        wt;
    logic        err;
    logic [31:0] lba;
  } obs_t;

  typedef struct {
    int    at;
    obs_t  v;
    string name;
  } exp_t;

  exp_t exp_q[$];
  obs_t ev;
  obs_t prev;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_en = 0;

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  always @(posedge clk_sys) cyc++;

  function automatic obs_t pack();
    return {hdd_mounted, hdd_protect, sd_rd, sd_wr, cpu_wait, hdd_error, sd_lba};
  endfunction

  // Monitor: each output change must match the next expected snapshot and edge count.
  always @(negedge clk_sys) begin
    obs_t cur;
    exp_t e;
    if (mon_en) begin
      cur = pack();
      if (cur !== prev) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_change cyc=%0d got=%h", cyc, cur);
        end else begin
          e = exp_q.pop_front();
          if (e.at != cyc || e.v !== cur) begin
            n_err++;
            $display("FAIL %s got=%h at cyc %0d, required=%h at cyc %0d", e.name, cur, cyc, e.v, e.at);
          end
        end
        n_cmp++;
        if (sd_rd && sd_wr) begin
          n_err++;
          $display("FAIL rd_wr_exclusive got rd=1 wr=1 at cyc %0d, required not both", cyc);
        end
        prev = cur;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic expect_at(input int at, input string nm);
    exp_t e;
    e.at = at;
    e.v = ev;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic check_now(input string nm);
    obs_t cur;
    cur = pack();
    n_cmp++;
    if (cur !== ev) begin
      n_err++;
      $display("FAIL %s got=%h required=%h", nm, cur, ev);
    end
  endtask

  task automatic pulse_rd(input logic [31:0] lba);
    hdd_read = 1'b1;
    hdd_lba_in = lba;
    tick(1);
    hdd_read = 1'b0;
  endtask

  task automatic pulse_wr(input logic [31:0] lba);
    hdd_write = 1'b1;
    hdd_lba_in = lba;
    tick(1);
    hdd_write = 1'b0;
  endtask

  task automatic mount(input logic [63:0] size, input logic ro);
    img_mounted = 1'b1;
    img_size = size;
    img_readonly = ro;
    tick(1);
    img_mounted = 1'b0;
  endtask

  // Ack high for 'hold' sampled cycles; returns at the edge that first samples ack low.
  task automatic ack_xfer(input int hold, input string nm);
    sd_ack = 1'b1;
    tick(1);
    ev.rd = 1'b0;
    ev.wr = 1'b0;
    expect_at(cyc + 1, {nm, "_ack_rise"});
    tick(hold - 1);
    sd_ack = 1'b0;
    tick(1);
    ev.wt = 1'b0;
    expect_at(cyc + 1, {nm, "_ack_fall"});
  endtask

  task automatic issue(input logic is_wr, input logic [31:0] lba, input int at, input string nm);
    ev.rd = !is_wr;
    ev.wr = is_wr;
    ev.wt = 1'b1;
    ev.err = 1'b0;
    ev.lba = lba;
    expect_at(at, nm);
  endtask

  initial begin
    int iss;
    reset = 1'b1;
    hdd_read = 1'b0;
    hdd_write = 1'b0;
    hdd_lba_in = '0;
    img_mounted = 1'b0;
    img_size = '0;
    img_readonly = 1'b0;
    sd_ack = 1'b0;
    ev = '0;
    tick(3);
    reset = 1'b0;
    tick(1);
    check_now("reset_state");
    prev = pack();
    mon_en = 1;

    // Read with no image mounted is rejected.
    pulse_rd(32'h3);
    ev.err = 1'b1;
    expect_at(cyc + 1, "unmounted_reject");
    tick(4);

    // Mount read-write image, then a basic read transfer.
    mount(64'h2000000, 1'b0);
    ev.mounted = 1'b1;
    expect_at(cyc, "mount_rw");
    tick(2);
    pulse_rd(32'h12);
    issue(1'b0, 32'h12, cyc + 1, "read_issue");
    tick(3);
    ack_xfer(64, "read");
    tick(3);

    // Read then write queued while busy: write served first, then the read.
    pulse_rd(32'h70);
    issue(1'b0, 32'h70, cyc + 1, "busy_issue");
    tick(1);
    pulse_rd(32'h5);
    pulse_wr(32'h9);
    tick(1);
    ack_xfer(8, "busy");
    issue(1'b1, 32'h9, cyc + 2, "write_first");
    tick(3);
    ack_xfer(8, "write");
    issue(1'b0, 32'h5, cyc + 2, "queued_read");
    tick(3);
    ack_xfer(8, "queued_read");
    tick(3);

    // Read-only image: write rejected, following read clears the error.
    mount(64'h2000000, 1'b1);
    ev.protect = 1'b1;
    expect_at(cyc, "mount_ro");
    tick(2);
    pulse_wr(32'h7);
    ev.err = 1'b1;
    expect_at(cyc + 1, "ro_write_reject");
    tick(4);
    pulse_rd(32'h20);
    issue(1'b0, 32'h20, cyc + 1, "read_clears_err");
    tick(2);
    ack_xfer(8, "ro_read");
    tick(3);

    // Zero-size image counts as unmounted.
    mount(64'h0, 1'b0);
    ev.mounted = 1'b0;
    ev.protect = 1'b0;
    expect_at(cyc, "unmount_size0");
    tick(2);
    pulse_rd(32'h21);
    ev.err = 1'b1;
    expect_at(cyc + 1, "size0_reject");
    tick(4);
    mount(64'h2000000, 1'b0);
    ev.mounted = 1'b1;
    expect_at(cyc, "remount");
    tick(2);

    // No ack: timeout TO edges after issue, late ack ignored.
    pulse_rd(32'h33);
    iss = cyc + 1;
    issue(1'b0, 32'h33, iss, "timeout_issue");
    ev.rd = 1'b0;
    ev.wt = 1'b0;
    ev.err = 1'b1;
    expect_at(iss + TO, "timeout");
    tick(TO + 5);
    sd_ack = 1'b1;
    tick(3);
    sd_ack = 1'b0;
    tick(6);
    check_now("late_ack_ignored");

    // Reset during XFER with a read queued: immediate clear, queued read lost.
    pulse_rd(32'h44);
    issue(1'b0, 32'h44, cyc + 1, "pre_reset_issue");
    tick(2);
    sd_ack = 1'b1;
    tick(1);
    ev.rd = 1'b0;
    expect_at(cyc + 1, "pre_reset_xfer");
    tick(3);
    pulse_rd(32'h55);
    tick(2);
    reset = 1'b1;
    #1;
    ev = '0;
    expect_at(cyc, "async_reset");
    check_now("reset_immediate");
    sd_ack = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(20);
    check_now("no_issue_after_reset");
    mount(64'h2000000, 1'b0);
    ev.mounted = 1'b1;
    expect_at(cyc, "mount_after_reset");
    tick(2);
    pulse_rd(32'h66);
    issue(1'b0, 32'h66, cyc + 1, "issue_after_reset");
    tick(5);

    while (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_cmp++;
      n_err++;
      $display("FAIL %s never observed, required=%h at cyc %0d", e.name, e.v, e.at);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
